// File: rtl/rgb_pwm_decoder.sv
// rgb_pwm_decoder: loopback monitor that recovers the 24-bit colour from the
// three PWM LED drives by counting high samples over free-running 256-cycle
// windows, accepts a colour once it repeats for STABLE_FRAMES windows, and
// reports its one-hot palette match.
module rgb_pwm_decoder #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_r,
  input  logic        pwm_g,
  input  logic        pwm_b,
  output logic [23:0] color,
  output logic        color_valid,
  output logic [7:0]  color_code,
  output logic        color_upd,
  output logic        frame_done
);

  localparam logic [3:0] MATCH_MAX = 4'(STABLE_FRAMES - 1);
  localparam bit         SINGLE    = (STABLE_FRAMES == 1);

  logic        m_r, m_g, m_b;
  logic        s_r, s_g, s_b;
  logic [7:0]  win;
  logic [8:0]  acc_r, acc_g, acc_b;
  logic [23:0] prev;
  logic [3:0]  match;

  logic [23:0] w;
  logic        eq;
  logic        accept;
  logic [3:0]  match_nxt;
  logic [7:0]  code_w;

  // Final sample of the window is folded in here; 256 highs saturates to FF.
  function automatic logic [7:0] sat_add(input logic [8:0] a, input logic s);
    logic [9:0] sum;
    sum = {1'b0, a} + {9'd0, s};
    sat_add = (sum > 10'd255) ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [7:0] palette(input logic [23:0] c);
    case (c)
      24'hFF0000: palette = 8'h01;
      24'hFF6600: palette = 8'h02;
      24'hFFFF00: palette = 8'h04;
      24'h00FF00: palette = 8'h08;
      24'h0000FF: palette = 8'h10;
      24'h000080: palette = 8'h20;
      24'h800080: palette = 8'h40;
      24'hFFFFFF: palette = 8'h80;
      default:    palette = 8'h00;
    endcase
  endfunction

  // Window value, stability decision and palette lookup at window close.
  always_comb begin
    w         = {sat_add(acc_r, s_r), sat_add(acc_g, s_g), sat_add(acc_b, s_b)};
    eq        = (w == prev);
    match_nxt = !eq ? 4'd0 : ((match >= MATCH_MAX) ? MATCH_MAX : match + 4'd1);
    accept    = SINGLE || (eq && (({1'b0, match} + 5'd1) >= {1'b0, MATCH_MAX}));
    code_w    = palette(w);
  end

  assign frame_done = (win == 8'hFF);

  // Two-flop synchroniser on each PWM drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {m_r, m_g, m_b} <= 3'b000;
      {s_r, s_g, s_b} <= 3'b000;
    end else begin
      {m_r, m_g, m_b} <= {pwm_r, pwm_g, pwm_b};
      {s_r, s_g, s_b} <= {m_r, m_g, m_b};
    end
  end

  // Window counter, accumulators, stability tracking and colour outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win         <= 8'd0;
      acc_r       <= 9'd0;
      acc_g       <= 9'd0;
      acc_b       <= 9'd0;
      prev        <= 24'd0;
      match       <= 4'd0;
      color       <= 24'd0;
      color_valid <= 1'b0;
      color_code  <= 8'd0;
      color_upd   <= 1'b0;
    end else begin
      win       <= win + 8'd1;
      color_upd <= 1'b0;
      if (win == 8'hFF) begin
        acc_r <= 9'd0;
        acc_g <= 9'd0;
        acc_b <= 9'd0;
        prev  <= w;
        match <= match_nxt;
        if (accept) begin
          color       <= w;
          color_valid <= 1'b1;
          color_code  <= code_w;
          color_upd   <= (w != color) || !color_valid;
        end
      end else begin
        acc_r <= acc_r + {8'd0, s_r};
        acc_g <= acc_g + {8'd0, s_g};
        acc_b <= acc_b + {8'd0, s_b};
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Bench for rgb_pwm_decoder: drives 256-periodic PWM at chosen phases and
// compares every cycle against a count-per-window model with a window
// history queue for the stability rule.
module tb_rgb_pwm_decoder;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pwm_r = 1'b0, pwm_g = 1'b0, pwm_b = 1'b0;
  logic [23:0] color;
  logic        color_valid;
  logic [7:0]  color_code;
  logic        color_upd;
  logic        frame_done;

  rgb_pwm_decoder #(.STABLE_FRAMES(N)) dut (
    .clk(clk), .rst(rst), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .color(color), .color_valid(color_valid), .color_code(color_code),
    .color_upd(color_upd), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // generator
  int gctr = 0;
  int duty_r = 0, duty_g = 0, duty_b = 0;

  // reference model
  int          m_win;
  int          m_cnt [3];
  int          d1 [3];
  int          d2 [3];
  logic [23:0] hist [$];
  logic [23:0] exp_color;
  logic        exp_valid, exp_upd, exp_fd;
  logic [7:0]  exp_code;

  logic [34:0] dut_vec, exp_vec;
  assign dut_vec = {frame_done, color_upd, color_valid, color_code, color};
  assign exp_vec = {exp_fd, exp_upd, exp_valid, exp_code, exp_color};

  function automatic logic [7:0] pal(input logic [23:0] c);
    case (c)
      24'hFF0000: pal = 8'h01;
      24'hFF6600: pal = 8'h02;
      24'hFFFF00: pal = 8'h04;
      24'h00FF00: pal = 8'h08;
      24'h0000FF: pal = 8'h10;
      24'h000080: pal = 8'h20;
      24'h800080: pal = 8'h40;
      24'hFFFFFF: pal = 8'h80;
      default:    pal = 8'h00;
    endcase
  endfunction

  task automatic model_clear();
    m_win = 0;
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; d1[i] = 0; d2[i] = 0; end
    hist.delete();
    hist.push_back(24'h0);
    exp_color = 0; exp_valid = 0; exp_upd = 0; exp_fd = 0; exp_code = 0;
  endtask

  task automatic model_step();
    int cur [3];
    int use_v [3];
    int wv [3];
    logic [23:0] w;
    bit ok;
    cur[0] = int'(pwm_r); cur[1] = int'(pwm_g); cur[2] = int'(pwm_b);
    for (int i = 0; i < 3; i++) begin
      use_v[i] = d2[i]; d2[i] = d1[i]; d1[i] = cur[i];
    end
    exp_upd = 0;
    if (m_win == 255) begin
      for (int i = 0; i < 3; i++) begin
        wv[i] = (m_cnt[i] + use_v[i] > 255) ? 255 : m_cnt[i] + use_v[i];
        m_cnt[i] = 0;
      end
      w = {8'(wv[0]), 8'(wv[1]), 8'(wv[2])};
      hist.push_back(w);
      if (hist.size() > 20) void'(hist.pop_front());
      ok = 1;
      if (N > 1) begin
        if (hist.size() < N) ok = 0;
        else for (int k = 1; k < N; k++) if (hist[hist.size() - 1 - k] != w) ok = 0;
      end
      if (ok) begin
        exp_upd   = (w != exp_color) || !exp_valid;
        exp_color = w;
        exp_valid = 1;
        exp_code  = pal(w);
      end
    end else begin
      for (int i = 0; i < 3; i++) m_cnt[i] += use_v[i];
    end
    m_win = (m_win + 1) % 256;
    exp_fd = (m_win == 255);
  endtask

  // Called at a negedge; returns at the next negedge with the model advanced.
  task automatic tick();
    pwm_r = (gctr < duty_r);
    pwm_g = (gctr < duty_g);
    pwm_b = (gctr < duty_b);
    @(posedge clk);
    if (rst) model_step();
    gctr = (gctr + 1) % 256;
    @(negedge clk);
  endtask

  task automatic set_duty(input int r, input int g, input int b);
    duty_r = r; duty_g = g; duty_b = b;
  endtask

  task automatic test_reset();
    rst = 0;
    model_clear();
    @(negedge clk);
    repeat (3) begin
      tick();
      if (dut_vec !== 35'd0) begin
        miscompares++;
        $display("FAIL reset_state: got %h need %h", dut_vec, 35'd0);
      end
      vectors++;
    end
    rst = 1;
  endtask

  task automatic test_red();
    int frames = 0, upds = 0, upd_frame = -1;
    gctr = 77;
    set_duty(255, 0, 0);
    repeat (5 * 256) begin
      tick();
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL red_cycle: got %h need %h", dut_vec, exp_vec);
      end
      vectors++;
      if (exp_fd) frames++;
      if (color_upd) begin upds++; if (upd_frame < 0) upd_frame = frames; end
    end
    if (upds != 1 || upd_frame < 2 || upd_frame > 3) begin
      miscompares++;
      $display("FAIL red_accept: got %0d upd at frame %0d need 1 upd at frame 2..3", upds, upd_frame);
    end
    vectors++;
    if ({color_valid, color_code, color} !== {1'b1, 8'h01, 24'hFF0000}) begin
      miscompares++;
      $display("FAIL red_color: got %b/%h/%h need 1/01/FF0000", color_valid, color_code, color);
    end
    vectors++;
  endtask

  task automatic test_palette();
    logic [23:0] cols [8];
    cols = '{24'hFF0000, 24'hFF6600, 24'hFFFF00, 24'h00FF00,
             24'h0000FF, 24'h000080, 24'h800080, 24'hFFFFFF};
    for (int k = 0; k < 8; k++) begin
      set_duty(int'(cols[k][23:16]), int'(cols[k][15:8]), int'(cols[k][7:0]));
      repeat (4 * 256) begin
        tick();
        if (dut_vec !== exp_vec) begin
          miscompares++;
          $display("FAIL palette_cycle[%0d]: got %h need %h", k, dut_vec, exp_vec);
        end
        vectors++;
      end
      if ({color_code, color} !== {8'(1 << k), cols[k]}) begin
        miscompares++;
        $display("FAIL palette[%0d]: got %h/%h need %h/%h", k, color_code, color, 8'(1 << k), cols[k]);
      end
      vectors++;
    end
  endtask

  task automatic test_switch();
    int frames = 0, upds = 0, guard = 0;
    set_duty(128, 0, 128);
    repeat (4 * 256) tick();
    while (m_win != 100 && guard < 300) begin tick(); guard++; end
    set_duty(0, 0, 128);
    guard = 0;
    while (frames < 3 && guard < 4 * 256) begin
      tick(); guard++;
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL switch_cycle: got %h need %h", dut_vec, exp_vec);
      end
      vectors++;
      if (exp_fd) frames++;
      if (color_upd) upds++;
    end
    if (frames != 3 || color !== 24'h800080 || upds != 0) begin
      miscompares++;
      $display("FAIL switch_hold: got frames %0d color %h upds %0d need 3 800080 0", frames, color, upds);
    end
    vectors++;
    tick();
    if ({color_upd, color_code, color} !== {1'b1, 8'h20, 24'h000080}) begin
      miscompares++;
      $display("FAIL switch_accept: got %b/%h/%h need 1/20/000080", color_upd, color_code, color);
    end
    vectors++;
    upds = 1;
    repeat (256) begin tick(); if (color_upd) upds++; end
    if (upds != 1) begin
      miscompares++;
      $display("FAIL switch_upd_count: got %0d need 1", upds);
    end
    vectors++;
  endtask

  task automatic test_saturate();
    set_duty(0, 0, 256);
    repeat (4 * 256) begin
      tick();
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL saturate_cycle: got %h need %h", dut_vec, exp_vec);
      end
      vectors++;
    end
    if ({color_code, color} !== {8'h10, 24'h0000FF}) begin
      miscompares++;
      $display("FAIL saturate: got %h/%h need 10/0000FF", color_code, color);
    end
    vectors++;
  endtask

  task automatic test_nonpalette();
    set_duty(8'h37, 8'h12, 8'hC8);
    repeat (4 * 256) begin
      tick();
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL nonpalette_cycle: got %h need %h", dut_vec, exp_vec);
      end
      vectors++;
    end
    if ({color_valid, color_code, color} !== {1'b1, 8'h00, 24'h3712C8}) begin
      miscompares++;
      $display("FAIL nonpalette: got %b/%h/%h need 1/00/3712C8", color_valid, color_code, color);
    end
    vectors++;
  endtask

  task automatic test_reset_mid();
    int guard = 0, first_fd = -1, closes = 0, acc_close = -1;
    while (m_win != 150 && guard < 300) begin tick(); guard++; end
    #2 rst = 0;
    #1;
    if (dut_vec !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h need %h", dut_vec, 35'd0);
    end
    vectors++;
    model_clear();
    @(negedge clk);
    gctr = (gctr + 1) % 256;
    repeat (2) tick();
    rst = 1;
    for (int k = 1; k <= 5 * 256; k++) begin
      tick();
      if (dut_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_reacq_cycle: got %h need %h", dut_vec, exp_vec);
      end
      vectors++;
      if (frame_done && first_fd < 0) first_fd = k;
      if (exp_fd) closes++;
      if (color_upd && acc_close < 0) acc_close = closes;
    end
    if (first_fd != 255) begin
      miscompares++;
      $display("FAIL reset_first_frame: got %0d need 255", first_fd);
    end
    vectors++;
    if (acc_close < N || color !== 24'h3712C8) begin
      miscompares++;
      $display("FAIL reset_reacquire: got close %0d color %h need >=%0d 3712C8", acc_close, color, N);
    end
    vectors++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      set_duty(int'($urandom_range(0, 256)), int'($urandom_range(0, 256)), int'($urandom_range(0, 256)));
      if (r == 4) gctr = int'($urandom_range(0, 255));
      repeat (int'($urandom_range(100, 900))) begin
        tick();
        if (dut_vec !== exp_vec) begin
          miscompares++;
          $display("FAIL random_cycle[%0d]: got %h need %h", r, dut_vec, exp_vec);
        end
        vectors++;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_red();
    test_palette();
    test_switch();
    test_saturate();
    test_nonpalette();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
